fetch_pc_t: RTL and testbench

FETCH_PC_T -- requirements
Module: fetch_pc_t

---
 rtl/fetch_pc_t.sv | 142 ++++++++++++++
 tb/tb_fetch_pc_t.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_t.sv
// Instruction fetch PC unit: one outstanding imem request, response held for decode.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects stop fetch and pulse misalign.
module fetch_pc_t (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ACT,
  input  logic [31:0] r_pc_D,
  input  logic        r_pc_WE,
  input  logic [31:0] redir_pc,
  input  logic        redir_valid,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        started_q, started_d;
  logic        kill_q, kill_d;

  logic        redir_bad;
  logic        redir_ok;
  logic        flush;
  logic        req_hs;
  logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign redir_bad = redir_valid & ~r_pc_WE & (redir_pc[1:0] != 2'b00);
  assign redir_tgt = redir_pc;
  assign misalign  = misalign_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) misalign_q <= 1'b0;
    else      misalign_q <= redir_bad;
  end
`else
  assign redir_bad = 1'b0;
  assign redir_tgt = redir_pc & ~32'h0000_0003;
  assign misalign  = 1'b0;
`endif

  assign redir_ok = redir_valid & ~r_pc_WE & ~redir_bad;
  assign flush    = r_pc_WE | redir_valid;

  // ACT only gates issue; responses cannot be backpressured so WAIT/HOLD keep moving.
  assign imem_req_valid = (state_q == S_REQ) & ACT;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

  assign if_valid = (state_q == S_HOLD);
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    started_d  = started_q;
    kill_d     = kill_q;

    if (r_pc_WE)       pc_d = r_pc_D;
    else if (redir_ok) pc_d = redir_tgt;
    else if (req_hs)   pc_d = pc_q + 32'd4;

    if (r_pc_WE)        started_d = 1'b1;
    else if (redir_bad) started_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (started_q && ACT && !redir_bad) state_d = S_REQ;
      end
      S_REQ: begin
        if (req_hs) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
          kill_d   = flush;
        end else if (redir_bad) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = started_d ? S_REQ : S_IDLE;
          end else begin
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = S_HOLD;
          end
        end else if (flush) begin
          // Request still in flight: remember to drop its response.
          kill_d = 1'b1;
        end
      end
      default: begin
        if (flush)         state_d = started_d ? S_REQ : S_IDLE;
        else if (if_ready) state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      pc_q       <= 32'h0000_0000;
      req_pc_q   <= 32'h0000_0000;
      if_pc_q    <= 32'h0000_0000;
      if_instr_q <= 32'h0000_0000;
      started_q  <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      started_q  <= started_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_t.sv
// Bench for fetch_pc_t: directed scenarios then random traffic, checked against
// a transaction-level model of requests, kills and deliveries.
module tb_fetch_pc_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ACT = 1'b1;
  logic [31:0] r_pc_D = '0;
  logic        r_pc_WE = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        redir_valid = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b1;
  logic        misalign;

  fetch_pc_t dut (
    .CLK(CLK), .RST(RST), .ACT(ACT),
    .r_pc_D(r_pc_D), .r_pc_WE(r_pc_WE),
    .redir_pc(redir_pc), .redir_valid(redir_valid),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
    .misalign(misalign)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: program counter, one in-flight request, one held instruction.
  logic [31:0] m_pc = '0;
  bit          m_started = 0;
  bit          m_out_any = 0;
  bit          m_out_live = 0;
  logic [31:0] m_out_addr = '0;
  bit          m_held = 0;
  logic [31:0] m_held_addr = '0;
  bit          m_exp_mis = 0;
  logic [31:0] dlv_q[$];
  logic [31:0] req_q[$];

  // Memory model
  int          lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit          hs, rsp, dl, flush, bad;
    logic [31:0] tgt;
    @(negedge CLK);
    if (!m_started || !ACT) chk("no_req", imem_req_valid, 0);
    if (imem_req_valid) begin
      chk("req_addr", imem_req_addr, m_pc);
      chk("one_outstanding", {m_out_any, m_held}, 0);
    end
    chk("if_valid", if_valid, m_held);
    if (m_held) begin
      chk("if_pc", if_pc, m_held_addr);
      chk("if_instr", if_instr, instr_of(m_held_addr));
    end
    chk("misalign", misalign, m_exp_mis);

    hs    = imem_req_valid & imem_req_ready;
    rsp   = imem_rsp_valid;
    dl    = if_valid & if_ready;
    flush = r_pc_WE | redir_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    bad = redir_valid && !r_pc_WE && (redir_pc % 4 != 0);
    tgt = redir_pc;
`else
    bad = 0;
    tgt = redir_pc - (redir_pc % 4);
`endif
    m_exp_mis = bad;
    if (rsp && m_out_any) begin
      if (m_out_live && !flush) begin
        m_held      = 1;
        m_held_addr = m_out_addr;
      end
      m_out_any  = 0;
      m_out_live = 0;
    end
    if (dl && !flush) begin
      dlv_q.push_back(m_held_addr);
      m_held = 0;
    end
    if (hs) begin
      req_q.push_back(m_pc);
      m_out_any  = 1;
      m_out_live = !flush;
      m_out_addr = m_pc;
      m_pc       = m_pc + 4;
    end
    if (flush) begin
      m_held     = 0;
      m_out_live = 0;
    end
    if (r_pc_WE) begin
      m_pc      = r_pc_D;
      m_started = 1;
    end else if (bad) begin
      m_started = 0;
    end else if (redir_valid) begin
      m_pc = tgt;
    end

    @(posedge CLK);
    #1;
    r_pc_WE        = 1'b0;
    redir_valid    = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (hs) begin
      mem_cnt  = lat;
      mem_addr = m_out_addr;
    end
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_addr);
      end
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int c = 0;
    while (dlv_q.size() < n && c < budget) begin
      step();
      c++;
    end
    chk("dlv_count", dlv_q.size(), n);
  endtask

  task automatic load_pc(input logic [31:0] a);
    r_pc_WE = 1'b1;
    r_pc_D  = a;
    step();
  endtask

  initial begin
    int          c;
    int          nreq;
    logic [31:0] snap_pc, snap_instr;

    #12;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_misalign", misalign, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    repeat (3) step();

    // Basic sequential fetch, 1-cycle memory
    dlv_q.delete();
    req_q.delete();
    load_pc(32'h1000);
    run_until(3, 40);
    chk("seq_dlv0", dlv_q[0], 32'h1000);
    chk("seq_dlv1", dlv_q[1], 32'h1004);
    chk("seq_dlv2", dlv_q[2], 32'h1008);
    chk("seq_req0", req_q[0], 32'h1000);

    // Decode stall in HOLD
    if_ready = 1'b0;
    c = 0;
    while (!m_held && c < 20) begin step(); c++; end
    chk("hold_reached", m_held, 1);
    snap_pc    = if_pc;
    snap_instr = if_instr;
    nreq       = req_q.size();
    repeat (4) step();
    chk("hold_pc_stable", if_pc, snap_pc);
    chk("hold_instr_stable", if_instr, snap_instr);
    chk("hold_no_req", req_q.size(), nreq);
    if_ready = 1'b1;

    // Memory not ready at 0x2000
    imem_req_ready = 1'b0;
    load_pc(32'h2000);
    nreq = req_q.size();
    repeat (4) step();
    chk("stall_valid", imem_req_valid, 1);
    chk("stall_addr", imem_req_addr, 32'h2000);
    chk("stall_no_hs", req_q.size(), nreq);
    imem_req_ready = 1'b1;
    dlv_q.delete();
    run_until(1, 20);
    chk("stall_dlv", dlv_q[0], 32'h2000);

    // Redirect while waiting for 0x1004
    lat = 3;
    dlv_q.delete();
    load_pc(32'h1000);
    c = 0;
    while (!(m_out_live && m_out_addr == 32'h1004) && c < 40) begin step(); c++; end
    chk("wait_1004", m_out_addr, 32'h1004);
    redir_valid = 1'b1;
    redir_pc    = 32'h3000;
    step();
    run_until(2, 40);
    chk("redir_dlv0", dlv_q[0], 32'h1000);
    chk("redir_dlv1", dlv_q[1], 32'h3000);

    // PC wrap
    lat = 1;
    dlv_q.delete();
    load_pc(32'hFFFF_FFFC);
    run_until(2, 40);
    chk("wrap_dlv0", dlv_q[0], 32'hFFFF_FFFC);
    chk("wrap_dlv1", dlv_q[1], 32'h0000_0000);

    // Misaligned redirect
    dlv_q.delete();
    redir_valid = 1'b1;
    redir_pc    = 32'h3002;
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    nreq = req_q.size();
    repeat (6) step();
    chk("mis_no_req", req_q.size(), nreq);
    load_pc(32'h4000);
`else
    run_until(1, 20);
    chk("mis_dlv", dlv_q[0], 32'h3000);
`endif

    // Random traffic
    dlv_q.delete();
    for (int i = 0; i < 600; i++) begin
      if (!m_started || $urandom_range(0, 60) == 0) begin
        r_pc_WE = 1'b1;
        r_pc_D  = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 15) == 0) begin
        redir_valid = 1'b1;
        redir_pc    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      end
      ACT            = ($urandom_range(0, 7) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(1, 3);
      step();
    end
    chk("rand_progress", (dlv_q.size() > 10), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
